// File: rtl/boot_copy_pkg.sv
// rtl/boot_copy_pkg.sv - shared state encoding and elaboration checks for the boot copy engine
package boot_copy_pkg;

   typedef enum logic [2:0] {
      ST_ARM,
      ST_FETCH,
      ST_WRITE,
      ST_EXEC,
      ST_FINISH
   } state_t;

   localparam int ROM_LAT_MAX = 3;

   function automatic bit lat_ok(input int lat);
      return (lat >= 0) && (lat <= ROM_LAT_MAX);
   endfunction

   // The index counter is ADDR_W+1 bits, so a full 2^ADDR_W image is still representable.
   function automatic bit len_ok(input int len, input int addr_w);
      return (len >= 0) && (longint'(len) <= (longint'(1) << addr_w));
   endfunction

endpackage

// File: rtl/boot_copy_csum.sv
// rtl/boot_copy_csum.sv - modular sum of accepted download words with compare against the expected image sum
module boot_copy_csum #(
   parameter int DATA_W      = 8,
   parameter int CSUM_EXPECT = 0
) (
   input  logic              i_clk_sys,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_add,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_sum_ok
);

   localparam logic [DATA_W-1:0] EXPECT_C = DATA_W'(CSUM_EXPECT);

   logic [DATA_W-1:0] r_sum;
   logic [DATA_W-1:0] w_sum_next;

   // The compare looks at the sum including the word being accepted this cycle.
   assign w_sum_next = r_sum + (i_add ? i_data : '0);
   assign o_sum_ok   = (w_sum_next == EXPECT_C);

   always_ff @(posedge i_clk_sys) begin
      if (i_reset || i_clear) begin
         r_sum <= '0;
      end else begin
         r_sum <= w_sum_next;
      end
   end

endmodule

// File: rtl/boot_copy_engine.sv
// rtl/boot_copy_engine.sv - boot-store to download-port copy sequencer with execute handoff
// Optional image checksum gate enabled by defining BOOT_COPY_CSUM_EN.
module boot_copy_engine
   import boot_copy_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int LEN         = 276,
   parameter int DEST_BASE   = 0,
   parameter int EXEC_ADDR   = 0,
   parameter int ROM_LAT     = 0,
   parameter int CSUM_EXPECT = 0
) (
   input  logic              i_clk_sys,
   input  logic              i_reset,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic              o_dn_go,
   output logic              o_dn_wr,
   output logic [ADDR_W-1:0] o_dn_addr,
   output logic [DATA_W-1:0] o_dn_data,
   input  logic              i_dn_wait,
   output logic [ADDR_W-1:0] o_execute_addr,
   output logic              o_execute_enable,
   output logic              o_done,
   output logic              o_csum_err
);

   localparam logic [ADDR_W:0]   LEN_C  = (ADDR_W+1)'(LEN);
   localparam logic [1:0]        LAT_C  = 2'(ROM_LAT);
   localparam logic [ADDR_W-1:0] DEST_C = ADDR_W'(DEST_BASE);
   localparam logic [ADDR_W-1:0] EXEC_C = ADDR_W'(EXEC_ADDR);

   if (!lat_ok(ROM_LAT)) begin : g_lat_err
      $error("boot_copy_engine: ROM_LAT must be within 0..%0d", ROM_LAT_MAX);
   end
   if (!len_ok(LEN, ADDR_W)) begin : g_len_err
      $error("boot_copy_engine: LEN exceeds 2^ADDR_W");
   end
   if (CSUM_EXPECT < 0) begin : g_csum_err
      $error("boot_copy_engine: CSUM_EXPECT must be non-negative");
   end

   state_t          r_state;
   logic [ADDR_W:0] r_idx;
   logic [1:0]      r_lat;
   logic [ADDR_W:0] w_idx_inc;
   logic            w_last;
   logic            w_end_ok;

   assign w_idx_inc = r_idx + 1'b1;
   assign w_last    = (w_idx_inc == LEN_C);

`ifdef BOOT_COPY_CSUM_EN
   logic w_accept;
   logic w_sum_clear;

   // Holding the sum cleared in ARM/FINISH covers both entry paths into FETCH.
   assign w_accept    = (r_state == ST_WRITE) && !i_dn_wait;
   assign w_sum_clear = (r_state == ST_ARM) || (r_state == ST_FINISH);

   boot_copy_csum #(
      .DATA_W      (DATA_W),
      .CSUM_EXPECT (CSUM_EXPECT)
   ) u_csum (
      .i_clk_sys (i_clk_sys),
      .i_reset   (i_reset),
      .i_clear   (w_sum_clear),
      .i_add     (w_accept),
      .i_data    (o_dn_data),
      .o_sum_ok  (w_end_ok)
   );
`else
   assign w_end_ok = 1'b1;
`endif

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_state          <= ST_ARM;
         r_idx            <= '0;
         r_lat            <= '0;
         o_rom_addr       <= '0;
         o_dn_go          <= 1'b0;
         o_dn_wr          <= 1'b0;
         o_dn_addr        <= '0;
         o_dn_data        <= '0;
         o_execute_addr   <= EXEC_C;
         o_execute_enable <= 1'b0;
         o_done           <= 1'b0;
         o_csum_err       <= 1'b0;
      end else begin
         o_execute_enable <= 1'b0;
         case (r_state)
            ST_ARM, ST_FINISH: begin
               if ((r_state == ST_ARM) || i_start) begin
                  r_idx      <= '0;
                  r_lat      <= '0;
                  o_rom_addr <= '0;
                  o_done     <= 1'b0;
                  o_csum_err <= 1'b0;
                  if (LEN_C == '0) begin
                     if (w_end_ok) begin
                        r_state          <= ST_EXEC;
                        o_execute_enable <= 1'b1;
                     end else begin
                        r_state    <= ST_FINISH;
                        o_done     <= 1'b1;
                        o_csum_err <= 1'b1;
                     end
                  end else begin
                     r_state <= ST_FETCH;
                     o_dn_go <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               // rom_addr has been stable since the first FETCH cycle, so data is valid now.
               if (r_lat == LAT_C) begin
                  r_state   <= ST_WRITE;
                  o_dn_wr   <= 1'b1;
                  o_dn_addr <= DEST_C + r_idx[ADDR_W-1:0];
                  o_dn_data <= i_rom_data;
               end else begin
                  r_lat <= r_lat + 1'b1;
               end
            end
            ST_WRITE: begin
               if (!i_dn_wait) begin
                  o_dn_wr <= 1'b0;
                  r_idx   <= w_idx_inc;
                  if (w_last) begin
                     o_dn_go <= 1'b0;
                     if (w_end_ok) begin
                        r_state          <= ST_EXEC;
                        o_execute_enable <= 1'b1;
                     end else begin
                        r_state    <= ST_FINISH;
                        o_done     <= 1'b1;
                        o_csum_err <= 1'b1;
                     end
                  end else begin
                     r_state    <= ST_FETCH;
                     r_lat      <= '0;
                     o_rom_addr <= w_idx_inc[ADDR_W-1:0];
                  end
               end
            end
            ST_EXEC: begin
               r_state <= ST_FINISH;
               o_done  <= 1'b1;
            end
            default: r_state <= ST_ARM;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_copy_engine.sv
// tb/tb_boot_copy_engine.sv - randomized self-checking bench for boot_copy_engine against a timeline model
module tb_boot_copy_engine;

   localparam int NI = 3;
   localparam int LAT_T  [NI] = '{0, 2, 3};
   localparam int LEN_T  [NI] = '{4, 4, 0};
   localparam int DEST_T [NI] = '{32'h0100, 32'hFFFE, 32'h0040};
   localparam int EXEC_T [NI] = '{32'h1234, 32'hBEEF, 32'h0777};
   localparam int CSUM_T [NI] = '{32'h00AB, 32'h0033, 32'h0000};

   logic        clk;
   logic        rst      [NI];
   logic        start    [NI];
   logic        dn_wait  [NI];
   logic [15:0] rom_addr [NI];
   logic [7:0]  rom_data [NI];
   logic        dn_go    [NI];
   logic        dn_wr    [NI];
   logic [15:0] dn_addr  [NI];
   logic [7:0]  dn_data  [NI];
   logic [15:0] ex_addr  [NI];
   logic        ex_en    [NI];
   logic        done     [NI];
   logic        cerr     [NI];
   logic [7:0]  rom_mem  [NI][8];

   int n_tests = 0;
   int n_fail  = 0;
   bit csum_on;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      boot_copy_engine #(
         .ADDR_W      (16),
         .DATA_W      (8),
         .LEN         (LEN_T[g]),
         .DEST_BASE   (DEST_T[g]),
         .EXEC_ADDR   (EXEC_T[g]),
         .ROM_LAT     (LAT_T[g]),
         .CSUM_EXPECT (CSUM_T[g])
      ) u_dut (
         .i_clk_sys        (clk),
         .i_reset          (rst[g]),
         .i_start          (start[g]),
         .o_rom_addr       (rom_addr[g]),
         .i_rom_data       (rom_data[g]),
         .o_dn_go          (dn_go[g]),
         .o_dn_wr          (dn_wr[g]),
         .o_dn_addr        (dn_addr[g]),
         .o_dn_data        (dn_data[g]),
         .i_dn_wait        (dn_wait[g]),
         .o_execute_addr   (ex_addr[g]),
         .o_execute_enable (ex_en[g]),
         .o_done           (done[g]),
         .o_csum_err       (cerr[g])
      );
      // Boot store: combinational, or a LAT-deep read pipeline.
      if (LAT_T[g] == 0) begin : g_comb
         assign rom_data[g] = rom_mem[g][rom_addr[g][2:0]];
      end else begin : g_pipe
         logic [7:0] pipe [LAT_T[g]];
         always @(posedge clk) begin
            pipe[0] <= rom_mem[g][rom_addr[g][2:0]];
            for (int n = 1; n < LAT_T[g]; n++) pipe[n] <= pipe[n-1];
         end
         assign rom_data[g] = pipe[LAT_T[g]-1];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_check(input int k);
      rst[k]     = 1'b1;
      start[k]   = 1'b1;
      dn_wait[k] = 1'b0;
      @(posedge clk);
      #1 start[k] = 1'b0;
      @(negedge clk);
      check($sformatf("k%0d rst ctl", k), {dn_go[k], dn_wr[k], ex_en[k], done[k], cerr[k]}, 0);
      check($sformatf("k%0d rst rom_addr", k), rom_addr[k], 0);
      check($sformatf("k%0d rst dn_addr", k), dn_addr[k], 0);
      check($sformatf("k%0d rst dn_data", k), dn_data[k], 0);
      check($sformatf("k%0d rst exec_addr", k), ex_addr[k], EXEC_T[k]);
   endtask

   // Model: word j fetches during [t[j], w[j]), writes during [w[j], t[j+1]) with s[j] stall cycles.
   // Cycle e is the cycle following edge e, where edge 0 samples the reset release or start pulse.
   task automatic run(input int k, input bit use_start, input int stop_word, input bit stall5);
      int lat, len, tend, sum, j;
      int s [8];
      int t [9];
      int w [8];
      bit ok, fetch, wrc, stall;
      logic [4:0] exp_ctl;
      lat  = LAT_T[k];
      len  = LEN_T[k];
      t[0] = 0;
      sum  = 0;
      for (int i = 0; i < len; i++) begin
         s[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         if (stall5 && i == 1) s[i] = 5;
         w[i]   = t[i] + lat + 1;
         t[i+1] = w[i] + s[i] + 1;
         sum   += int'(rom_mem[k][i]);
      end
      tend = t[len];
      ok   = !csum_on || ((sum & 255) == CSUM_T[k]);
      @(posedge clk);
      #1;
      if (use_start) start[k] = 1'b1;
      else rst[k] = 1'b0;
      for (int e = 0; e <= tend + 2; e++) begin
         @(posedge clk);
         #1;
         if (stop_word >= 0 && e == t[stop_word]) begin
            start[k] = 1'b0;
            return;
         end
         j = 0;
         while (j < len && e >= t[j+1]) j++;
         fetch = (j < len) && (e < w[j]);
         wrc   = (j < len) && (e >= w[j]);
         stall = wrc && (e < w[j] + s[j]);
         dn_wait[k] = wrc ? stall : 1'($urandom_range(0, 1));
         start[k]   = (e < tend) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         exp_ctl = {e < tend, wrc, ok && (e == tend), ok ? (e > tend) : (e >= tend), !ok && (e >= tend)};
         check($sformatf("k%0d ctl e%0d", k, e), {dn_go[k], dn_wr[k], ex_en[k], done[k], cerr[k]}, exp_ctl);
         if (fetch) check($sformatf("k%0d rom_addr e%0d", k, e), rom_addr[k], j);
         if (wrc) begin
            check($sformatf("k%0d dn_addr e%0d", k, e), dn_addr[k], (DEST_T[k] + j) & 32'hFFFF);
            check($sformatf("k%0d dn_data e%0d", k, e), dn_data[k], rom_mem[k][j]);
         end
         if (e == tend) check($sformatf("k%0d exec_addr", k), ex_addr[k], EXEC_T[k]);
      end
      dn_wait[k] = 1'b0;
   endtask

   task automatic fill_rom(input int k);
      for (int i = 0; i < 8; i++) rom_mem[k][i] = 8'($urandom);
   endtask

   initial begin
`ifdef BOOT_COPY_CSUM_EN
      csum_on = 1'b1;
`else
      csum_on = 1'b0;
`endif
      for (int k = 0; k < NI; k++) begin
         rst[k]     = 1'b1;
         start[k]   = 1'b0;
         dn_wait[k] = 1'b0;
         fill_rom(k);
      end
      repeat (3) @(posedge clk);
      for (int k = 0; k < NI; k++) reset_check(k);

      // Image sum 0xAA against expected 0xAB, then corrected image re-run by start.
      rom_mem[0][0] = 8'h11;
      rom_mem[0][1] = 8'h22;
      rom_mem[0][2] = 8'h33;
      rom_mem[0][3] = 8'h44;
      run(0, 1'b0, -1, 1'b0);
      rom_mem[0][3] = 8'h45;
      run(0, 1'b1, -1, 1'b0);

      // Wrapping destination with a 5-cycle stall on the second write.
      run(1, 1'b0, -1, 1'b1);
      // Abort after two writes, then a clean copy from word 0.
      run(1, 1'b1, 2, 1'b0);
      reset_check(1);
      run(1, 1'b0, -1, 1'b0);

      // Zero-length image.
      run(2, 1'b0, -1, 1'b0);
      run(2, 1'b1, -1, 1'b0);

      for (int it = 0; it < 8; it++) begin
         int k;
         k = int'($urandom_range(0, NI - 1));
         fill_rom(k);
         if ($urandom_range(0, 1) == 1) begin
            reset_check(k);
            run(k, 1'b0, -1, 1'b0);
         end else begin
            run(k, 1'b1, -1, 1'b0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
